// File: rtl/gp_command_processor.sv
// -----------------------------------------------------------------------------
// gp_command_processor
//
// Graphics-side command processor. A start strobe latches a command-list pointer
// and a frame-buffer base. 32-bit command words are fetched over a read
// handshake. FILL rectangles are rastered as one write per pixel. A one-cycle
// interrupt is pulsed when the list ends.
//
// Command words:
//   w0[31:24] opcode (0x00 STOP, 0x01 FILL), w0[23:0] fill colour
//   w1 = {x0, y0}, w2 = {x1, y1}; 16-bit fields, low COORD_W bits used
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   gp_code           command-list byte address (word aligned)
//   gp_frame          frame-buffer base byte address
//   gp_valid          start strobe, accepted only while idle
//   frame_interrupt   one-cycle pulse when the list terminates
//   busy              high whenever not idle
//   gp_err            sticky error, cleared by the next accepted start
//   cmd_rd_*          command read handshake (req/addr out, ack/data in)
//   px_wr_*           pixel write handshake (req/addr/data out, ack in)
//
// Optional build macro GP_WATCHDOG_EN: counts decoded FILL commands and aborts
// the list with gp_err once MAX_CMDS have been executed. Without the macro the
// list runs until STOP or an unknown opcode, and MAX_CMDS has no effect.
// -----------------------------------------------------------------------------
module gp_command_processor #(
    parameter int COORD_W        = 10,
    parameter int FB_STRIDE_LOG2 = 10,
    parameter int MAX_CMDS       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gp_code,
    input  logic [31:0] gp_frame,
    input  logic        gp_valid,
    output logic        frame_interrupt,
    output logic        busy,
    output logic        gp_err,
    output logic        cmd_rd_req,
    output logic [31:0] cmd_rd_addr,
    input  logic        cmd_rd_ack,
    input  logic [31:0] cmd_rd_data,
    output logic        px_wr_req,
    output logic [31:0] px_wr_addr,
    output logic [31:0] px_wr_data,
    input  logic        px_wr_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_FILL,
        S_DONE
    } state_e;

    localparam logic [7:0] OP_STOP = 8'h00;
    localparam logic [7:0] OP_FILL = 8'h01;

    state_e state_q, state_d;

    logic [31:0]        ptr_q, ptr_d;
    logic [31:0]        fb_q, fb_d;
    logic [23:0]        color_q, color_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               err_q, err_d;
    // One idle cycle after every completed transfer, so req is low the cycle
    // after its ack and a new request starts one cycle later.
    logic               gap_q, gap_d;

    logic               start;
    logic               rd_fire;
    logic               wr_fire;
    logic               wd_trip;
    logic               rect_empty;
    logic               last_x;
    logic               last_y;
    logic [7:0]         opcode;
    logic [COORD_W-1:0] fld_hi;
    logic [COORD_W-1:0] fld_lo;
    logic [31:0]        px_offset;

    assign start   = (state_q == S_IDLE) && gp_valid;
    assign rd_fire = cmd_rd_req && cmd_rd_ack;
    assign wr_fire = px_wr_req && px_wr_ack;
    assign opcode  = cmd_rd_data[31:24];
    assign fld_hi  = cmd_rd_data[16 +: COORD_W];
    assign fld_lo  = cmd_rd_data[0 +: COORD_W];
    assign last_x  = (x_q == x1_q);
    assign last_y  = (y_q == y1_q);

    // Decided while w2 is on the bus, so an empty rectangle never enters FILL.
    assign rect_empty = (fld_hi < x0_q) || (fld_lo < y0_q);

    // Unused upper field bits (beyond COORD_W) are intentionally ignored.
    logic unused_rd_bits;
    assign unused_rd_bits = ^cmd_rd_data;

`ifdef GP_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_CMDS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (state_q == S_F0 && rd_fire && opcode == OP_FILL) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Evaluated before the opcode fetch; the counter cannot pass MAX_CMDS.
    assign wd_trip = (state_q == S_F0) && (cnt_q >= CNT_W'(MAX_CMDS));
`else
    localparam int unused_max_cmds = MAX_CMDS;
    assign wd_trip = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default first so every path assigns state_d; no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (gp_valid) state_d = S_F0;
            S_F0: begin
                if (wd_trip) begin
                    state_d = S_DONE;
                end else if (rd_fire) begin
                    state_d = (opcode == OP_FILL) ? S_F1 : S_DONE;
                end
            end
            S_F1:   if (rd_fire) state_d = S_F2;
            S_F2:   if (rd_fire) state_d = rect_empty ? S_F0 : S_FILL;
            S_FILL: if (wr_fire && last_x && last_y) state_d = S_F0;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cmd_rd_req      = 1'b0;
        px_wr_req       = 1'b0;
        frame_interrupt = 1'b0;
        busy            = (state_q != S_IDLE);
        unique case (state_q)
            S_F0:       cmd_rd_req      = !gap_q && !wd_trip;
            S_F1, S_F2: cmd_rd_req      = !gap_q;
            S_FILL:     px_wr_req       = !gap_q;
            S_DONE:     frame_interrupt = 1'b1;
            default: ;
        endcase
    end

    assign px_offset   = ((32'(y_q) << FB_STRIDE_LOG2) + 32'(x_q)) << 2;
    assign px_wr_addr  = fb_q + px_offset;
    assign px_wr_data  = {8'h00, color_q};
    assign cmd_rd_addr = ptr_q;
    assign gp_err      = err_q;

    // ---------------- datapath next-state ----------------
    always_comb begin
        ptr_d   = ptr_q;
        fb_d    = fb_q;
        color_d = color_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        gap_d   = rd_fire || wr_fire;

        if (start) begin
            ptr_d = gp_code;
            fb_d  = gp_frame;
            err_d = 1'b0;
        end

        if (rd_fire) ptr_d = ptr_q + 32'd4;

        unique case (state_q)
            S_F0: begin
                if (wd_trip) begin
                    err_d = 1'b1;
                end else if (rd_fire) begin
                    color_d = cmd_rd_data[23:0];
                    if (opcode != OP_STOP && opcode != OP_FILL) err_d = 1'b1;
                end
            end
            S_F1: begin
                if (rd_fire) begin
                    x0_d = fld_hi;
                    y0_d = fld_lo;
                end
            end
            S_F2: begin
                if (rd_fire) begin
                    x1_d = fld_hi;
                    y1_d = fld_lo;
                    x_d  = x0_q;
                    y_d  = y0_q;
                end
            end
            S_FILL: begin
                if (wr_fire) begin
                    if (last_x) begin
                        x_d = x0_q;
                        y_d = y_q + COORD_W'(1);
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            fb_q    <= '0;
            color_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            fb_q    <= fb_d;
            color_q <= color_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

endmodule
